// File: rtl/move_sequencer_if.sv
// Control bus, reduction-tree sample and move stream between move_sequencer and its neighbours.
// master = sequencer side; slave = array / search-engine / stimulus side.
interface move_sequencer_if;
  logic       start;
  logic       wtm_in;
  logic       abort;
  logic [2:0] state_mode;
  logic [1:0] mask_mode;
  logic       wtm;
  logic [5:0] sel_square;
  logic       sel_en;
  logic [2:0] arb_prio;
  logic [5:0] arb_square;
  logic       any_king;
  logic       move_valid;
  logic       move_ready;
  logic [5:0] move_from;
  logic [5:0] move_to;
  logic [2:0] move_prio;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [7:0] move_count;

  modport master (
    input  start, wtm_in, abort, arb_prio, arb_square, any_king, move_ready,
    output state_mode, mask_mode, wtm, sel_square, sel_en,
           move_valid, move_from, move_to, move_prio,
           busy, done, illegal, move_count
  );

  modport slave (
    output start, wtm_in, abort, arb_prio, arb_square, any_king, move_ready,
    input  state_mode, mask_mode, wtm, sel_square, sel_en,
           move_valid, move_from, move_to, move_prio,
           busy, done, illegal, move_count
  );
endinterface

// File: rtl/move_sequencer.sv
// MVV-LVA move sequencer: walks victims (FV) and aggressors (FA) over the square array
// via the broadcast bus and streams (from, to, prio) moves; flags capturable enemy king.
module move_sequencer #(
  parameter int unsigned ARB_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  move_sequencer_if.master bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SQ_W   = 6;
  localparam int unsigned PRIO_W = 3;
  localparam int unsigned MC_W   = 8;
  localparam int unsigned SM_W   = 3;
  localparam int unsigned MM_W   = 2;

  localparam logic [SM_W-1:0] SM_FV      = 3'd0;
  localparam logic [SM_W-1:0] SM_FA      = 3'd1;
  localparam logic [MM_W-1:0] MM_EAV_EAA = 2'b00;
  localparam logic [MM_W-1:0] MM_DV_EAA  = 2'b01;
  localparam logic [MM_W-1:0] MM_DA      = 2'b10;
  localparam logic [MM_W-1:0] MM_IDLE    = 2'b11;

  localparam logic [CNT_W-1:0] LAT      = CNT_W'(ARB_LATENCY);
  localparam logic [MC_W-1:0]  MC_MAX   = {MC_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FV, S_FA, S_EMIT, S_DIS_AGG, S_DIS_VIC, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SQ_W-1:0]     victim_q, victim_d;

  logic [SM_W-1:0]     state_mode_q, state_mode_d;
  logic [MM_W-1:0]     mask_mode_q, mask_mode_d;
  logic                wtm_q, wtm_d;
  logic [SQ_W-1:0]     sel_square_q, sel_square_d;
  logic                sel_en_q, sel_en_d;
  logic                move_valid_q, move_valid_d;
  logic [SQ_W-1:0]     move_from_q, move_from_d;
  logic [SQ_W-1:0]     move_to_q, move_to_d;
  logic [PRIO_W-1:0]   move_prio_q, move_prio_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic [MC_W-1:0]     move_count_q, move_count_d;

  logic                xfer_c;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      victim_q     <= '0;
      state_mode_q <= SM_FV;
      mask_mode_q  <= MM_IDLE;
      wtm_q        <= 1'b0;
      sel_square_q <= '0;
      sel_en_q     <= 1'b0;
      move_valid_q <= 1'b0;
      move_from_q  <= '0;
      move_to_q    <= '0;
      move_prio_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      state_mode_q <= state_mode_d;
      mask_mode_q  <= mask_mode_d;
      wtm_q        <= wtm_d;
      sel_square_q <= sel_square_d;
      sel_en_q     <= sel_en_d;
      move_valid_q <= move_valid_d;
      move_from_q  <= move_from_d;
      move_to_q    <= move_to_d;
      move_prio_q  <= move_prio_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      move_count_q <= move_count_d;
    end
  end

  assign xfer_c = (state_q == S_EMIT) && move_valid_q && bus.move_ready;

  // Next state and next output values; bus outputs are decoded from the next state
  // so that each registered output lines up with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    wtm_d        = wtm_q;
    move_from_d  = move_from_q;
    move_to_d    = move_to_q;
    move_prio_d  = move_prio_q;
    illegal_d    = illegal_q;
    move_count_d = move_count_q;

    if (bus.abort) begin
      state_d   = S_IDLE;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            wtm_d        = bus.wtm_in;
            move_count_d = '0;
            illegal_d    = 1'b0;
            state_d      = S_INIT;
          end
        end
        S_INIT: begin
          state_d = S_FV;
          cnt_d   = LAT;
        end
        S_FV: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (bus.arb_prio == '0) begin
            state_d = S_DONE;
          end else if (bus.any_king) begin
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            victim_d = bus.arb_square;
            state_d  = S_FA;
            cnt_d    = LAT;
          end
        end
        S_FA: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (bus.arb_prio == '0) begin
            state_d = S_DIS_VIC;
          end else begin
            move_from_d = bus.arb_square;
            move_to_d   = victim_q;
            move_prio_d = bus.arb_prio;
            state_d     = S_EMIT;
          end
        end
        S_EMIT: begin
          if (xfer_c) begin
            move_count_d = (move_count_q == MC_MAX) ? move_count_q
                                                    : move_count_q + MC_W'(1);
            state_d      = S_DIS_AGG;
          end
        end
        S_DIS_AGG: begin
          state_d = S_FA;
          cnt_d   = LAT;
        end
        S_DIS_VIC: begin
          state_d = S_FV;
          cnt_d   = LAT;
        end
        default: state_d = S_IDLE;
      endcase
    end

    state_mode_d = SM_FV;
    mask_mode_d  = MM_IDLE;
    sel_square_d = sel_square_q;
    sel_en_d     = 1'b0;
    case (state_d)
      S_INIT: mask_mode_d = MM_EAV_EAA;
      S_FA: begin
        state_mode_d = SM_FA;
        sel_square_d = victim_d;
        sel_en_d     = 1'b1;
      end
      S_EMIT: state_mode_d = SM_FA;
      S_DIS_AGG: begin
        state_mode_d = SM_FA;
        mask_mode_d  = MM_DA;
        sel_square_d = move_from_d;
        sel_en_d     = 1'b1;
      end
      S_DIS_VIC: begin
        state_mode_d = SM_FA;
        mask_mode_d  = MM_DV_EAA;
        sel_square_d = victim_d;
        sel_en_d     = 1'b1;
      end
      default: ;
    endcase

    move_valid_d = (state_d == S_EMIT);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
  end

  assign bus.state_mode = state_mode_q;
  assign bus.mask_mode  = mask_mode_q;
  assign bus.wtm        = wtm_q;
  assign bus.sel_square = sel_square_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.move_valid = move_valid_q;
  assign bus.move_from  = move_from_q;
  assign bus.move_to    = move_to_q;
  assign bus.move_prio  = move_prio_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.illegal    = illegal_q;
  assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: array arbitration responses are driven from
// per-phase tables (FV vs FA) and outputs are checked cycle-exactly against hand values.
module tb_move_sequencer;

  localparam logic [2:0] SM_FV      = 3'd0;
  localparam logic [2:0] SM_FA      = 3'd1;
  localparam logic [1:0] MM_EAV_EAA = 2'b00;
  localparam logic [1:0] MM_DV_EAA  = 2'b01;
  localparam logic [1:0] MM_DA      = 2'b10;
  localparam logic [1:0] MM_IDLE    = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_sequencer_if bus();

  move_sequencer #(.ARB_LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0] fv_prio, fa_prio;
  logic [5:0] fv_sq, fa_sq;
  logic       king;
  int         total = 0;
  int         bad = 0;
  int         valid_seen = 0;

  // Array model: reduction-tree answer depends only on the broadcast mode.
  always_comb begin
    bus.arb_prio   = (bus.state_mode == SM_FA) ? fa_prio : fv_prio;
    bus.arb_square = (bus.state_mode == SM_FA) ? fa_sq : fv_sq;
    bus.any_king   = king;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.move_valid) valid_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.wtm_in = 1'b0; bus.abort = 1'b0; bus.move_ready = 1'b0;
    fv_prio = '0; fa_prio = '0; fv_sq = '0; fa_sq = '0; king = 1'b0;
    #2;
    check("rst_state_mode", 32'(bus.state_mode), 32'(SM_FV));
    check("rst_mask_mode", 32'(bus.mask_mode), 32'(MM_IDLE));
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_valid", 32'(bus.move_valid), 0);
    check("rst_count", 32'(bus.move_count), 0);
    check("rst_sel_en", 32'(bus.sel_en), 0);
    check("rst_wtm", 32'(bus.wtm), 0);
    run(2);
    rst = 1'b0;
    step();

    // Empty position: FV finds no victim
    valid_seen = 0;
    bus.wtm_in = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t1_init_mask", 32'(bus.mask_mode), 32'(MM_EAV_EAA));
    check("t1_init_busy", 32'(bus.busy), 1);
    check("t1_wtm", 32'(bus.wtm), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_fv_mode", 32'(bus.state_mode), 32'(SM_FV));
      check("t1_fv_mask", 32'(bus.mask_mode), 32'(MM_IDLE));
      check("t1_fv_done", 32'(bus.done), 0);
    end
    step();
    check("t1_done", 32'(bus.done), 1);
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_illegal", 32'(bus.illegal), 0);
    check("t1_count", 32'(bus.move_count), 0);
    check("t1_no_valid", 32'(valid_seen), 0);

    // One capture, consumer ready, then aggressor exhausted and victim list empty
    fv_prio = 3'd6; fv_sq = 6'd27; fa_prio = 3'd4; fa_sq = 6'd12; bus.move_ready = 1'b1;
    bus.wtm_in = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t2_wtm", 32'(bus.wtm), 0);
    check("t2_count_clr", 32'(bus.move_count), 0);
    run(4);
    check("t2_fa_mode", 32'(bus.state_mode), 32'(SM_FA));
    check("t2_fa_sel", 32'(bus.sel_square), 27);
    check("t2_fa_sel_en", 32'(bus.sel_en), 1);
    run(3);
    check("t2_valid", 32'(bus.move_valid), 1);
    check("t2_from", 32'(bus.move_from), 12);
    check("t2_to", 32'(bus.move_to), 27);
    check("t2_prio", 32'(bus.move_prio), 4);
    check("t2_emit_mask", 32'(bus.mask_mode), 32'(MM_IDLE));
    check("t2_emit_sel_en", 32'(bus.sel_en), 0);
    step();
    check("t2_da_mask", 32'(bus.mask_mode), 32'(MM_DA));
    check("t2_da_sel", 32'(bus.sel_square), 12);
    check("t2_da_sel_en", 32'(bus.sel_en), 1);
    check("t2_da_count", 32'(bus.move_count), 1);
    check("t2_da_valid", 32'(bus.move_valid), 0);
    fa_prio = 3'd0;
    run(4);
    check("t2_dv_mask", 32'(bus.mask_mode), 32'(MM_DV_EAA));
    check("t2_dv_sel", 32'(bus.sel_square), 27);
    check("t2_dv_sel_en", 32'(bus.sel_en), 1);
    fv_prio = 3'd0;
    step();
    check("t2_fv_again", 32'(bus.state_mode), 32'(SM_FV));
    check("t2_fv_mask", 32'(bus.mask_mode), 32'(MM_IDLE));
    run(3);
    check("t2_done", 32'(bus.done), 1);
    check("t2_count_end", 32'(bus.move_count), 1);

    // Back-pressure: consumer stalls five cycles in EMIT
    fv_prio = 3'd6; fv_sq = 6'd27; fa_prio = 3'd4; fa_sq = 6'd12; bus.move_ready = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run(7);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(bus.move_valid), 1);
      check("t3_hold_from", 32'(bus.move_from), 12);
      check("t3_hold_to", 32'(bus.move_to), 27);
      check("t3_hold_prio", 32'(bus.move_prio), 4);
      check("t3_hold_mask", 32'(bus.mask_mode), 32'(MM_IDLE));
      check("t3_hold_sel_en", 32'(bus.sel_en), 0);
      check("t3_hold_count", 32'(bus.move_count), 0);
      if (i != 4) step();
    end
    bus.move_ready = 1'b1;
    step();
    check("t3_da_mask", 32'(bus.mask_mode), 32'(MM_DA));
    check("t3_count", 32'(bus.move_count), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t3_abort_busy", 32'(bus.busy), 0);
    check("t3_abort_done", 32'(bus.done), 0);

    // Capturable enemy king: illegal position
    valid_seen = 0;
    fv_prio = 3'd7; fv_sq = 6'd4; king = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run(4);
    check("t4_done", 32'(bus.done), 1);
    check("t4_illegal", 32'(bus.illegal), 1);
    check("t4_count", 32'(bus.move_count), 0);
    check("t4_no_valid", 32'(valid_seen), 0);
    king = 1'b0; fv_prio = 3'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t4_restart_illegal", 32'(bus.illegal), 0);
    check("t4_restart_done", 32'(bus.done), 0);
    check("t4_restart_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // Start while busy is ignored; abort beats the EMIT handshake
    fv_prio = 3'd6; fv_sq = 6'd27; fa_prio = 3'd4; fa_sq = 6'd12; bus.move_ready = 1'b1;
    bus.wtm_in = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run(2);
    bus.start = 1'b1; bus.wtm_in = 1'b0;
    step();
    bus.start = 1'b0;
    check("t5_busy_start_wtm", 32'(bus.wtm), 1);
    check("t5_busy_start_mode", 32'(bus.state_mode), 32'(SM_FV));
    check("t5_busy_start_mask", 32'(bus.mask_mode), 32'(MM_IDLE));
    step();
    check("t5_fa_sel", 32'(bus.sel_square), 27);
    run(3);
    check("t5_emit_valid", 32'(bus.move_valid), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t5_abort_valid", 32'(bus.move_valid), 0);
    check("t5_abort_count", 32'(bus.move_count), 0);
    check("t5_abort_busy", 32'(bus.busy), 0);
    check("t5_abort_done", 32'(bus.done), 0);
    check("t5_abort_mask", 32'(bus.mask_mode), 32'(MM_IDLE));
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_start_abort_busy", 32'(bus.busy), 0);
    check("t5_start_abort_mask", 32'(bus.mask_mode), 32'(MM_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Top-level sequencer for the 64-square move-generation array. Drives the broadcast control bus (state_mode, mask_mode, wtm, square select) through the MVV-LVA victim/aggressor loop and samples the array's external max-priority reduction tree. Emits (from, to, prio) moves one at a time over a valid/ready stream to the search engine. Also detects an illegal position, i.e. a side-not-to-move king that can be captured.

Parameters:
ARB_LATENCY, 2, cycles from a control-bus change to valid arb_prio/arb_square at the reduction-tree output (0..15)
MM_IDLE, 2'b11, mask_mode code that leaves all masks unchanged

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  pulse: begin generation for side wtm_in; ignored while busy=1
wtm_in  input  1  side to move, latched on accepted start
abort  input  1  return to IDLE next cycle from any state
state_mode  output  3  broadcast mode to all squares (`SM_FV / `SM_FA codes)
mask_mode  output  2  broadcast mask command (`MM_EAV_EAA / `MM_DV_EAA / `MM_DA / MM_IDLE)
wtm  output  1  latched side to move
sel_square  output  6  selected square index; decoded to per-square ss1 elsewhere
sel_en  output  1  sel_square is valid (ss1 asserted on that square)
arb_prio  input  3  max prio across all squares; 0 = none
arb_square  input  6  square index holding arb_prio (lowest index on tie)
any_king  input  1  OR of all square king outputs
move_valid  output  1  move available
move_ready  input  1  consumer accepts move
move_from  output  6  aggressor square
move_to  output  6  victim square
move_prio  output  3  aggressor prio captured at FA_EVAL
busy  output  1  not in IDLE/DONE
done  output  1  generation complete (level until start/abort)
illegal  output  1  valid with done: position illegal
move_count  output  8  moves emitted this run, saturates at 255

Behaviour:
- Reset (async, rst=1): state IDLE. state_mode=`SM_FV, mask_mode=MM_IDLE, wtm=0, sel_square=0, sel_en=0, move_valid=0, move_from/to/prio=0, busy=0, done=0, illegal=0, move_count=0, cnt=0.
- IDLE: mask_mode=MM_IDLE, sel_en=0. On start, latch wtm<=wtm_in, clear move_count/done/illegal, go to INIT.
- INIT (1 cycle): mask_mode=`MM_EAV_EAA, which enables all victims and aggressors. Then go to FV with cnt<=ARB_LATENCY.
- FV: state_mode=`SM_FV, sel_en=0. cnt decrements each cycle. At cnt==0, sample arb/any_king:
  - any_king=1 and arb_prio!=0: illegal<=1, go to DONE.
  - arb_prio==0: go to DONE (illegal=0).
  - otherwise: victim<=arb_square, go to FA with cnt<=ARB_LATENCY.
  - FV therefore lasts ARB_LATENCY+1 cycles.
- FA: state_mode=`SM_FA, sel_square=victim, sel_en=1. At cnt==0:
  - arb_prio==0: go to DIS_VIC.
  - otherwise: move_from<=arb_square, move_to<=victim, move_prio<=arb_prio, go to EMIT.
- EMIT: move_valid=1. Bus holds `SM_FA with sel_en=0 and MM_IDLE. Transfer occurs on move_valid&&move_ready. Then move_count++ (saturating at 255) and go to DIS_AGG. move_from/to/prio are stable while valid.
- DIS_AGG (1 cycle): mask_mode=`MM_DA, sel_square=move_from, sel_en=1. Then go to FA with cnt<=ARB_LATENCY.
- DIS_VIC (1 cycle): mask_mode=`MM_DV_EAA, sel_square=victim, sel_en=1. Then go to FV with cnt<=ARB_LATENCY.
- DONE: done=1, busy=0, bus idle (MM_IDLE, sel_en=0). start is accepted here as in IDLE.
- abort: takes priority over every other transition, including the EMIT handshake completing the same cycle. Next state is IDLE, move_valid drops next cycle, move_count is not incremented, and done=0, illegal=0. Square masks are not restored; the next start goes through INIT.
- start is ignored when busy=1. start and abort in the same cycle: abort wins.
- ARB_LATENCY=0: each FV/FA lasts exactly 1 cycle.
- mask_mode is MM_IDLE in every state except INIT, DIS_AGG and DIS_VIC.

Test Plan:
- ARB_LATENCY=2, start wtm_in=1, arb_prio=0 in FV -> FV held 3 cycles, then done=1, illegal=0, move_count=0, no move_valid.
- FV arb (prio=6, sq=27); FA arb (prio=4, sq=12); move_ready=1 -> move_from=12, move_to=27, move_prio=4. Next cycle: mask_mode=`MM_DA, sel_square=12, move_count=1.
- Same as above with move_ready low 5 cycles -> move_valid held, outputs stable, state stays EMIT, bus idle.
- After a move, FA returns prio 0 -> DIS_VIC cycle with `MM_DV_EAA, sel_square=27; FV re-entered; FV then returns 0 -> done.
- FV with any_king=1 and arb_prio=7 -> illegal=1, done=1, no move emitted.
- abort asserted in EMIT together with move_ready=1 -> IDLE next cycle, move_valid=0, move_count unchanged; start while busy=1 has no effect.
